// File: rtl/fifo1c_arb_pkg.sv
// Shared types and widths for the fifo1c write arbiter.
package fifo1c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } arb_st_t;

   localparam int ARB_ID_W = 3;
   localparam int BURST_W  = 8;

endpackage

// File: rtl/fifo1c_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr_i, wrapping mod N.
module rr_pick
   import fifo1c_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]        valid_i,
   input  logic [ARB_ID_W-1:0] ptr_i,
   output logic [N-1:0]        onehot_o,
   output logic [ARB_ID_W-1:0] idx_o,
   output logic                any_o
);

   logic                found;
   logic [N-1:0]        oh;
   logic [ARB_ID_W-1:0] idx;

   always_comb begin
      found = 1'b0;
      oh    = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && valid_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
               found = 1'b1;
               oh[i] = 1'b1;
               idx   = ARB_ID_W'(i);
            end
         end
      end
      onehot_o = oh;
      idx_o    = idx;
      any_o    = found;
   end

endmodule

// File: rtl/fifo1c_wr_arb.sv
// Round-robin, packet-atomic write arbiter in front of a fifo1c128x64 write port.
module fifo1c_wr_arb
   import fifo1c_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]            req_eop,
   output logic [NREQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]      fifo_data,
   output logic                       fifo_wrreq,
   input  logic                       fifo_almost_full,
   input  logic                       fifo_full,
   output logic [ARB_ID_W-1:0]        grant_id,
   output logic                       grant_active,
   output logic                       ovf_err,
   input  logic                       err_clr
);

   arb_st_t               state_q, state_d;
   logic [ARB_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ARB_ID_W-1:0]   grant_id_q, grant_id_d;
   logic [NREQ-1:0]       gnt_oh_q, gnt_oh_d;
   logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
   logic                  fifo_wrreq_q, fifo_wrreq_d;
   logic                  ovf_err_q, ovf_err_d;

   logic [NREQ-1:0]       pick_oh;
   logic [ARB_ID_W-1:0]   pick_idx;
   logic                  pick_any;

   logic                  sel_valid, sel_eop;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  accept, burst_last, xfer_done;
   logic [BURST_W:0]      burst_inc;

   rr_pick #(.N(NREQ)) u_pick (
      .valid_i  (req_valid),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         gnt_oh_q     <= '0;
         burst_cnt_q  <= '0;
         fifo_data_q  <= '0;
         fifo_wrreq_q <= 1'b0;
         ovf_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         gnt_oh_q     <= gnt_oh_d;
         burst_cnt_q  <= burst_cnt_d;
         fifo_data_q  <= fifo_data_d;
         fifo_wrreq_q <= fifo_wrreq_d;
         ovf_err_q    <= ovf_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid) state_d = ARB;
         ARB:     state_d = pick_any ? XFER : IDLE;
         XFER:    if (xfer_done) state_d = ARB;
         default: state_d = IDLE;
      endcase
   end

   // Ready depends only on state and almost_full, so requesters may wait on it.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh_q[i]) sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      sel_valid    = |(req_valid & gnt_oh_q);
      sel_eop      = |(req_eop & gnt_oh_q);
      req_ready    = ((state_q == XFER) && !fifo_almost_full) ? gnt_oh_q : '0;
      accept       = (state_q == XFER) && !fifo_almost_full && sel_valid;
      burst_inc    = {1'b0, burst_cnt_q} + 1'b1;
      burst_last   = (burst_inc == (BURST_W+1)'(MAX_BURST));
      xfer_done    = accept && (sel_eop || burst_last);
      grant_active = (state_q == XFER);
      grant_id     = grant_id_q;
      fifo_data    = fifo_data_q;
      fifo_wrreq   = fifo_wrreq_q;
      ovf_err      = ovf_err_q;
   end

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      gnt_oh_d     = gnt_oh_q;
      burst_cnt_d  = burst_cnt_q;
      fifo_wrreq_d = accept;
      fifo_data_d  = accept ? sel_data : fifo_data_q;
      if ((state_q == ARB) && pick_any) begin
         grant_id_d  = pick_idx;
         gnt_oh_d    = pick_oh;
         burst_cnt_d = '0;
      end
      if (accept) burst_cnt_d = burst_inc[BURST_W-1:0];
      if (xfer_done) begin
         rr_ptr_d = (grant_id_q == ARB_ID_W'(NREQ-1)) ? '0 : grant_id_q + 1'b1;
      end
      // A same-cycle overflow wins over the clear so no event is lost.
      if (fifo_wrreq_q && fifo_full) ovf_err_d = 1'b1;
      else if (err_clr)              ovf_err_d = 1'b0;
      else                           ovf_err_d = ovf_err_q;
   end

endmodule
